// File: rtl/debug_frame_unit_if.sv
// UART byte link between the debug frame unit and its rx/tx byte engines.
// The slave side is the debug frame unit; the master side is the UART.
interface debug_frame_unit_if;
  logic       rx_done_tick;
  logic [7:0] rx_bus;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_bus;

  modport master (
    output rx_done_tick, rx_bus, tx_done_tick,
    input  tx_start, tx_bus
  );

  modport slave (
    input  rx_done_tick, rx_bus, tx_done_tick,
    output tx_start, tx_bus
  );
endinterface

// File: rtl/debug_frame_unit.sv
// UART-driven pipeline debug controller: run/step/stop/reset via command bytes,
// and after every stop it streams a header, the cycle count and a latched state snapshot.
module debug_frame_unit #(
  parameter int         SNAP_BYTES = 64,
  parameter int         CNT_BYTES  = 4,
  parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
  input  logic                    top_clk,
  input  logic                    rst,
  debug_frame_unit_if.slave       link,
  input  logic                    halt,
  input  logic [SNAP_BYTES*8-1:0] snapshot,
  output logic                    pipe_en,
  output logic                    rst_pipe,
  output logic                    busy
);
  localparam int SNAP_W    = SNAP_BYTES * 8;
  localparam int CNT_W     = CNT_BYTES * 8;
  localparam int FRAME_LEN = 1 + CNT_BYTES + SNAP_BYTES;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, RUN, STEP, LATCH, SEND, WAIT_TX} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [SNAP_W-1:0]      shadow;
  logic [IDX_W-1:0]       byte_idx, byte_idx_next, next_idx;
  logic [8*FRAME_LEN-1:0] frame;
  logic [7:0]             next_byte, tx_bus_q, tx_bus_next;
  logic                   tx_start_q, tx_start_next;
  logic                   pipe_en_next, rst_pipe_next, clr_cnt, latch_snap;

  assign link.tx_start = tx_start_q;
  assign link.tx_bus   = tx_bus_q;

  // Frame image with byte 0 in the low bits: header, counter LSB-first, then the shadow.
  assign frame = {shadow, cycle_cnt, HDR_BYTE};

  always_comb begin
    next_idx  = byte_idx + IDX_W'(1);
    next_byte = HDR_BYTE;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (next_idx == IDX_W'(i)) next_byte = frame[8*i +: 8];
    end
  end

  always_ff @(posedge top_clk) begin
    if (rst) begin
      state      <= IDLE;
      pipe_en    <= 1'b0;
      rst_pipe   <= 1'b1;
      tx_start_q <= 1'b0;
      tx_bus_q   <= 8'h00;
      busy       <= 1'b0;
      byte_idx   <= '0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_next;
      pipe_en    <= pipe_en_next;
      rst_pipe   <= rst_pipe_next;
      tx_start_q <= tx_start_next;
      tx_bus_q   <= tx_bus_next;
      busy       <= (state_next != IDLE);
      byte_idx   <= byte_idx_next;
      if (clr_cnt)
        cycle_cnt <= '0;
      else if (pipe_en && !(&cycle_cnt))
        cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge top_clk) begin
    if (latch_snap) shadow <= snapshot;
  end

  // pipe_en is registered, so the decision for the coming cycle is made one state early.
  always_comb begin
    state_next    = state;
    pipe_en_next  = 1'b0;
    rst_pipe_next = 1'b0;
    tx_start_next = 1'b0;
    tx_bus_next   = tx_bus_q;
    byte_idx_next = byte_idx;
    clr_cnt       = 1'b0;
    latch_snap    = 1'b0;
    case (state)
      IDLE: begin
        if (link.rx_done_tick) begin
          case (link.rx_bus)
            8'h63: begin
              state_next   = RUN;
              pipe_en_next = !halt;
            end
            8'h73: begin
              state_next   = STEP;
              pipe_en_next = !halt;
            end
            8'h64: state_next = LATCH;
            8'h72: begin
              rst_pipe_next = 1'b1;
              clr_cnt       = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (halt || (link.rx_done_tick && link.rx_bus == 8'h78))
          state_next = LATCH;
        else
          pipe_en_next = 1'b1;
      end
      STEP: state_next = LATCH;
      LATCH: begin
        latch_snap    = 1'b1;
        byte_idx_next = '0;
        tx_start_next = 1'b1;
        tx_bus_next   = HDR_BYTE;
        state_next    = SEND;
      end
      SEND: state_next = WAIT_TX;
      WAIT_TX: begin
        if (link.tx_done_tick) begin
          if (byte_idx == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            byte_idx_next = next_idx;
            tx_start_next = 1'b1;
            tx_bus_next   = next_byte;
            state_next    = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_debug_frame_unit.sv
// Scoreboard bench for debug_frame_unit: expected tx bytes are queued when a command
// is issued and popped by a UART responder that answers each tx_start 3 cycles later.
module tb_debug_frame_unit;
  localparam int SNAP_BYTES = 4;
  localparam int CNT_BYTES  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [31:0] snapshot;
  logic        pipe_en, rst_pipe, busy;

  debug_frame_unit_if link();

  debug_frame_unit #(
    .SNAP_BYTES(SNAP_BYTES),
    .CNT_BYTES (CNT_BYTES),
    .HDR_BYTE  (8'hA5)
  ) dut (
    .top_clk (clk),
    .rst     (rst),
    .link    (link),
    .halt    (halt),
    .snapshot(snapshot),
    .pipe_en (pipe_en),
    .rst_pipe(rst_pipe),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          tx_cnt = 0;
  int          pe_cnt = 0;
  int          countdown = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_byte = 8'h00;
  logic [15:0] exp_cycles = 16'h0000;

  initial forever begin
    @(negedge clk);
    if (pipe_en === 1'b1) pe_cnt++;
  end

  // UART tx model: each tx_start pops the scoreboard, tx_done_tick follows 3 cycles later.
  initial begin
    link.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      link.tx_done_tick = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          link.tx_done_tick = 1'b1;
          if (busy === 1'b1) begin
            checks++;
            if (link.tx_bus !== last_byte) begin
              errors++;
              $display("[TB] FAIL tx_bus_hold: got %h expected %h", link.tx_bus, last_byte);
            end
          end
        end
      end
      if (link.tx_start === 1'b1) begin
        tx_cnt++;
        countdown = 3;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          last_byte = link.tx_bus;
          $display("[TB] FAIL tx_unexpected: got byte %h expected no tx_start", link.tx_bus);
        end else begin
          last_byte = exp_q.pop_front();
          if (link.tx_bus !== last_byte) begin
            errors++;
            $display("[TB] FAIL tx_byte: got %h expected %h", link.tx_bus, last_byte);
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    link.rx_bus       = b;
    link.rx_done_tick = 1'b1;
    @(negedge clk);
    link.rx_done_tick = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] cnt, input logic [31:0] snap);
    exp_q.push_back(8'hA5);
    exp_q.push_back(cnt[7:0]);
    exp_q.push_back(cnt[15:8]);
    for (int i = 0; i < SNAP_BYTES; i++) exp_q.push_back(snap[8*i +: 8]);
  endtask

  task automatic wait_frame_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("[TB] FAIL %s_frame_end: got %0d bytes pending busy=%b expected 0 pending busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_tx_count(input int target, input string name);
    int n = 0;
    while (tx_cnt < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (tx_cnt < target) begin
      errors++;
      $display("[TB] FAIL %s_tx_wait: got %0d tx_start expected %0d", name, tx_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rst_pipe !== 1'b1) begin errors++; $display("[TB] FAIL reset_rst_pipe: got %b expected 1", rst_pipe); end
    checks++;
    if (pipe_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_pipe_en: got %b expected 0", pipe_en); end
    checks++;
    if (link.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", link.tx_start); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (link.tx_bus !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_bus: got %h expected 00", link.tx_bus); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rst_pipe !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got rst_pipe=%b expected 0", rst_pipe); end
  endtask

  task automatic test_single_step();
    snapshot   = 32'h44332211;
    pe_cnt     = 0;
    tx_cnt     = 0;
    exp_cycles = exp_cycles + 16'd1;
    push_frame(exp_cycles, snapshot);
    send_cmd(8'h73);
    wait_frame_done("step");
    checks++;
    if (pe_cnt != 1) begin errors++; $display("[TB] FAIL step_pipe_en: got %0d cycles expected 1", pe_cnt); end
    checks++;
    if (tx_cnt != 7) begin errors++; $display("[TB] FAIL step_tx_count: got %0d expected 7", tx_cnt); end
  endtask

  task automatic test_run_halt();
    int n = 0;
    snapshot   = 32'hDDCCBBAA;
    pe_cnt     = 0;
    exp_cycles = exp_cycles + 16'd5;
    push_frame(exp_cycles, 32'hDDCCBBAA);
    send_cmd(8'h63);
    while (pe_cnt < 5 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    halt = 1'b1;
    repeat (4) @(negedge clk);
    snapshot = 32'h99999999;
    wait_frame_done("run_halt");
    checks++;
    if (pe_cnt != 5) begin errors++; $display("[TB] FAIL run_halt_pipe_en: got %0d cycles expected 5", pe_cnt); end
  endtask

  task automatic test_halt_on_entry();
    pe_cnt   = 0;
    snapshot = 32'h55667788;
    push_frame(exp_cycles, snapshot);
    send_cmd(8'h63);
    wait_frame_done("halt_run");
    push_frame(exp_cycles, snapshot);
    send_cmd(8'h73);
    wait_frame_done("halt_step");
    checks++;
    if (pe_cnt != 0) begin errors++; $display("[TB] FAIL halt_entry_pipe_en: got %0d cycles expected 0", pe_cnt); end
    halt = 1'b0;
  endtask

  task automatic test_run_stop();
    snapshot   = 32'hCAFEF00D;
    pe_cnt     = 0;
    tx_cnt     = 0;
    exp_cycles = exp_cycles + 16'd4;
    push_frame(exp_cycles, snapshot);
    send_cmd(8'h63);
    send_cmd(8'h73);
    @(negedge clk);
    link.rx_bus       = 8'h78;
    link.rx_done_tick = 1'b1;
    checks++;
    if (pipe_en !== 1'b1) begin errors++; $display("[TB] FAIL stop_before: got pipe_en=%b expected 1", pipe_en); end
    @(negedge clk);
    link.rx_done_tick = 1'b0;
    checks++;
    if (pipe_en !== 1'b0) begin errors++; $display("[TB] FAIL stop_after: got pipe_en=%b expected 0", pipe_en); end
    wait_tx_count(2, "stop");
    send_cmd(8'h64);
    wait_frame_done("stop");
    repeat (10) @(negedge clk);
    checks++;
    if (tx_cnt != 7) begin errors++; $display("[TB] FAIL stop_tx_count: got %0d expected 7", tx_cnt); end
    checks++;
    if (pe_cnt != 4) begin errors++; $display("[TB] FAIL stop_pipe_en: got %0d cycles expected 4", pe_cnt); end
  endtask

  task automatic test_soft_reset();
    send_cmd(8'h72);
    checks++;
    if (rst_pipe !== 1'b1) begin errors++; $display("[TB] FAIL soft_reset_pulse: got %b expected 1", rst_pipe); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL soft_reset_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (rst_pipe !== 1'b0) begin errors++; $display("[TB] FAIL soft_reset_width: got %b expected 0", rst_pipe); end
    exp_cycles = 16'h0000;
    tx_cnt     = 0;
    send_cmd(8'h41);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({pipe_en, rst_pipe, busy, link.tx_start} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL unknown_cmd: got %b expected 0000", {pipe_en, rst_pipe, busy, link.tx_start});
      end
      @(negedge clk);
    end
    snapshot = 32'h87654321;
    push_frame(exp_cycles, snapshot);
    send_cmd(8'h64);
    wait_frame_done("soft_reset");
    checks++;
    if (tx_cnt != 7) begin errors++; $display("[TB] FAIL soft_reset_tx_count: got %0d expected 7", tx_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    snapshot = 32'h0F0E0D0C;
    tx_cnt   = 0;
    push_frame(16'h0000, snapshot);
    send_cmd(8'h64);
    wait_tx_count(3, "abort");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tx_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (tx_cnt != 0) begin errors++; $display("[TB] FAIL abort_tx_stop: got %0d tx_start expected 0", tx_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    push_frame(16'h0000, snapshot);
    send_cmd(8'h64);
    wait_frame_done("after_abort");
    checks++;
    if (tx_cnt != 7) begin errors++; $display("[TB] FAIL after_abort_tx_count: got %0d expected 7", tx_cnt); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    halt              = 1'b0;
    snapshot          = 32'h0;
    link.rx_done_tick = 1'b0;
    link.rx_bus       = 8'h00;
    test_reset();
    test_single_step();
    test_run_halt();
    test_halt_on_entry();
    test_run_stop();
    test_soft_reset();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
